// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch; owns the PC, issues word fetches, buffers replies for decode.
//   Optional macro IFETCH_PERF_CNT_EN adds perf_starve_cnt / perf_flush_cnt.
//   Ports: clk, reset (async, active-low); imem_req/imem_addr/imem_gnt request side;
//   imem_rvalid/imem_rdata response side; redirect_valid/redirect_pc from EX;
//   id_valid/id_ready/id_instr/id_pc handshake to decode.
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_starve_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
    state_t          state, state_nx;
    logic [XLEN-1:0] fetch_pc, req_pc;
    logic [XLEN-1:0] q_pc [FQ_DEPTH];
    logic [31:0]     q_instr [FQ_DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            grant, push, pop;
    logic            unused_bits;
    assign unused_bits = ^redirect_pc[1:0];
    // Gated with reset so nothing is requested while held in reset.
    assign imem_req  = reset && state == IDLE && count < FULL && !redirect_valid;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    // A redirect kills both the same-cycle push and pop.
    assign push      = imem_rvalid && state == WAIT && !redirect_valid;
    assign pop       = id_valid && id_ready && !redirect_valid;
    assign id_valid  = count != '0;
    assign id_pc     = q_pc[head];
    assign id_instr  = q_instr[head];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? WAIT : IDLE;
            WAIT:    state_nx = imem_rvalid ? IDLE : (redirect_valid ? DISCARD : WAIT);
            DISCARD: state_nx = imem_rvalid ? IDLE : DISCARD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    req_pc   <= fetch_pc;
                end
                if (push) tail <= tail + AW'(1);
                if (pop) head <= head + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= req_pc;
            q_instr[tail] <= imem_rdata;
        end
    end
    // Issue is gated on free space, so a push into a full queue means broken gating.
    assert property (@(posedge clk) disable iff (!reset) !(push && count == FULL));
`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_starve_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (id_ready && !id_valid && !redirect_valid && perf_starve_cnt != '1)
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            if (redirect_valid && (count != '0 || state != IDLE) && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized and directed checking of if_fetch_stage against a transaction-level model.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr, id_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_starve_cnt, perf_flush_cnt;
`endif
    always #5 clk = ~clk;
    if_fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_starve_cnt(perf_starve_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );
    int checks = 0, passed = 0;
    int cyc = 0;
    // Model: entries decode should see, the one outstanding memory request, next fetch address.
    logic [31:0] mq[$];
    bit          pending = 0, stale = 0;
    logic [31:0] pend_addr = '0, next_fetch = '0;
    int          log_pc[$], log_cyc[$];
    longint      starve = 0, flush = 0;
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    endtask
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy, input bit g, input bit rv);
        bit exp_req, fire, resp;
        @(negedge clk);
        redirect_valid = rd;
        redirect_pc    = rpc;
        id_ready       = rdy;
        imem_gnt       = g;
        resp           = pending && rv;
        imem_rvalid    = resp;
        imem_rdata     = resp ? memf(pend_addr) : $urandom;
        #1;
        exp_req = !pending && mq.size() < 2 && !rd;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, next_fetch);
        chk("id_valid", id_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("id_pc", id_pc, mq[0]);
            chk("id_instr", id_instr, memf(mq[0]));
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_starve", perf_starve_cnt, starve);
        chk("perf_flush", perf_flush_cnt, flush);
`endif
        if (rdy && mq.size() == 0 && !rd) starve++;
        if (rd && (mq.size() > 0 || pending)) flush++;
        fire = exp_req && g;
        if (rd) begin
            mq.delete();
            next_fetch = {rpc[31:2], 2'b00};
            if (resp) pending = 0;
            else if (pending) stale = 1;
        end else begin
            if (mq.size() > 0 && rdy) begin
                log_pc.push_back(mq[0]);
                log_cyc.push_back(cyc);
                void'(mq.pop_front());
            end
            if (resp) begin
                if (!stale) mq.push_back(pend_addr);
                pending = 0;
            end
            if (fire) begin
                pending    = 1;
                stale      = 0;
                pend_addr  = next_fetch;
                next_fetch = next_fetch + 32'd4;
            end
        end
        cyc++;
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_id_valid", id_valid, 0);
        mq.delete();
        pending = 0;
        stale = 0;
        next_fetch = '0;
        starve = 0;
        flush = 0;
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_perf_starve", perf_starve_cnt, 0);
        chk("rst_perf_flush", perf_flush_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        log_pc.delete();
        log_cyc.delete();
    endtask
    initial begin
        int n;
        do_reset();
        // Streaming from reset: one entry every two cycles.
        n = cyc;
        repeat (10) step(0, 0, 1, 1, 1);
        chk("t1_entries", log_pc.size() >= 3, 1);
        chk("t1_pc0", log_pc[0], 32'h0);
        chk("t1_pc1", log_pc[1], 32'h4);
        chk("t1_pc2", log_pc[2], 32'h8);
        chk("t1_first_cyc", log_cyc[0] - n, 2);
        chk("t1_period", log_cyc[1] - log_cyc[0], 2);
        // Decode stalls: queue fills, request stops, drains in order.
        do_reset();
        repeat (10) step(0, 0, 0, 1, 1);
        chk("t2_req_full", imem_req, 0);
        chk("t2_id_valid", id_valid, 1);
        repeat (10) step(0, 0, 1, 1, 1);
        chk("t2_pc0", log_pc[0], 32'h0);
        chk("t2_pc1", log_pc[1], 32'h4);
        chk("t2_pc2", log_pc[2], 32'h8);
        // Redirect while waiting; stale reply arrives a cycle later.
        do_reset();
        step(0, 0, 1, 1, 0);
        n = cyc;
        step(1, 32'h100, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        repeat (6) step(0, 0, 1, 1, 1);
        chk("t3_pc", log_pc[0], 32'h100);
        chk("t3_cyc", log_cyc[0] - n, 4);
        // Redirect coinciding with the reply; unaligned target.
        do_reset();
        step(0, 0, 1, 1, 0);
        step(1, 32'h103, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_req", imem_req, 1);
        repeat (6) step(0, 0, 1, 1, 1);
        chk("t4_pc", log_pc[0], 32'h100);
        // Redirect with a full queue and a same-cycle pop.
        do_reset();
        repeat (10) step(0, 0, 0, 1, 1);
        log_pc.delete();
        log_cyc.delete();
        step(1, 32'h200, 1, 1, 1);
        @(posedge clk);
        #1;
        chk("t5_id_valid", id_valid, 0);
        repeat (10) step(0, 0, 1, 1, 1);
        chk("t5_pc0", log_pc[0], 32'h200);
        chk("t5_pc1", log_pc[1], 32'h204);
        chk("t5_pc2", log_pc[2], 32'h208);
`ifdef IFETCH_PERF_CNT_EN
        do_reset();
        repeat (5) step(0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("t6_starve", perf_starve_cnt, 5);
        repeat (4) step(0, 0, 0, 1, 1);
        step(1, 32'h40, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1, 1);
        step(1, 32'h80, 0, 1, 1);
        @(posedge clk);
        #1;
        chk("t6_flush", perf_flush_cnt, 2);
`endif
        // Random traffic with occasional mid-run reset.
        do_reset();
        repeat (4000) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
